rx_unstuff_shifter: RTL
=======================

Name: rx_unstuff_shifter

Overview:
- USB receive-path stage directly downstream of the NRZI decoder.
- Consumes the decoded serial bit stream (`d_orig`) on each `shift_enable` strobe.
- Removes stuffed bits (a forced 0 after STUFF_LEN consecutive 1s) and assembles LSB-first bytes.
- Presents each completed byte with a one-cycle valid pulse to the RX controller/FIFO, and flags bit-stuff violations and non-byte-aligned EOPs.

Parameters:
- BYTE_W, 8, width of an assembled data word.
- STUFF_LEN, 6, number of consecutive accepted 1s after which the next bit is a stuff bit.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- d_orig  input  1  decoded serial data bit; valid when shift_enable=1.
- shift_enable  input  1  single-cycle strobe, one per received bit period.
- eop  input  1  level, high while end-of-packet (SE0) is present on the bus.
- clear  input  1  synchronous packet-start clear from the RX controller.
- rx_byte  output  BYTE_W  last completed byte; held until the next completion.
- byte_valid  output  1  one-cycle pulse, rx_byte updated this cycle.
- stuff_err  output  1  one-cycle pulse, bit-stuff violation detected.
- align_err  output  1  one-cycle pulse, EOP began with a partial byte pending.

Behaviour:
- Clock and reset are decided: one clock (`clk`); reset (`rst`) is asynchronous and active-high.
- Reset values: rx_byte=0, byte_valid=0, stuff_err=0, align_err=0; internal shreg=0, bit_cnt=0, ones_cnt=0, eop_q=0.
- Internal state:
  - shreg[BYTE_W-1:0]: assembly register.
  - bit_cnt[$clog2(BYTE_W)-1:0]: accepted bits in the current byte.
  - ones_cnt[$clog2(STUFF_LEN+1)-1:0]: run of consecutive accepted 1s.
  - eop_q: eop delayed one cycle.
- Per-cycle priority: rst > clear > eop > shift_enable.
- clear=1: shreg, bit_cnt and ones_cnt go to 0; rx_byte is held; all pulse outputs are 0 next cycle.
- eop=1: any shift_enable that cycle is ignored; bit_cnt and ones_cnt go to 0; shreg is held.
- EOP rising edge (eop=1, eop_q=0) with bit_cnt!=0: align_err=1 for exactly the next cycle. No pulse when bit_cnt==0.
- shift_enable=1 and ones_cnt==STUFF_LEN (stuff slot):
  - The bit is never shifted; bit_cnt is unchanged; ones_cnt goes to 0.
  - d_orig=0: legal stuff bit, discarded silently.
  - d_orig=1: stuff_err=1 for one cycle.
- shift_enable=1 and ones_cnt<STUFF_LEN (data bit):
  - shreg <= {d_orig, shreg[BYTE_W-1:1]}, i.e. LSB first; the first bit lands in rx_byte[0].
  - ones_cnt <= d_orig ? ones_cnt+1 : 0.
  - bit_cnt increments and wraps to 0 after BYTE_W-1.
- Byte completion: on acceptance of the bit with bit_cnt==BYTE_W-1, rx_byte <= {d_orig, shreg[BYTE_W-1:1]} and byte_valid=1 on the following cycle.
  - Latency: 1 clock from the final accepted shift_enable edge.
- The ones run spans byte boundaries; ones_cnt is not reset at byte completion.
- Outputs are registered; byte_valid, stuff_err and align_err never stay high for more than 1 cycle.
- shift_enable with eop=0 and clear=0 while idle is processed normally. The decoder idles at 1 and shift_enable is only produced in-packet, so this case never occurs in practice.
- Reset mid-byte: partial byte lost; the next byte after release assembles from bit 0.

Decomposition:
- Package rx_pkg:
  - BYTE_W and STUFF_LEN default constants.
  - typedef rx_byte_t (logic [BYTE_W-1:0]).
  - Shared by the NRZI decoder, this block, the RX FIFO and the RX controller.
- Sub-module rx_stuff_counter:
  - Owns ones_cnt.
  - Outputs is_stuff_slot (ones_cnt==STUFF_LEN) and stuff_violation (slot && d_orig).
  - Inputs: shift_enable, d_orig, clear-or-eop.
- The top-level handles shreg, bit_cnt, output registers and eop edge detection.

Test Plan:
- Bits 1,0,1,0,0,1,0,1 on 8 strobes, 8 clocks apart -> byte_valid single pulse 1 cycle after the 8th strobe; rx_byte=0xA5; no errors.
- Eight data 1s sent as 1×6, stuffed 0, 1×2 (9 strobes) -> rx_byte=0xFF, one byte_valid, stuff_err never asserted.
- Seven consecutive 1s from bit 0 -> stuff_err pulse after the 7th strobe; 7th bit discarded; bit_cnt=6. Then 0,0 -> rx_byte=0x3F.
- 3 data bits, then eop high for 2 cycles -> align_err exactly one pulse; no byte_valid. A following 0x5A assembles correctly.
- eop and shift_enable in the same cycle at bit_cnt=0 -> bit ignored, no align_err. clear with shift_enable -> bit ignored, counters 0.
- rst asserted asynchronously after 5 bits (mid-cycle) -> all outputs 0 immediately. After release, a new 0xC3 yields rx_byte=0xC3.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared constants and types for the USB receive path: NRZI decoder,
// unstuffer/shifter, RX FIFO and RX controller.
package rx_pkg;

    localparam int BYTE_W    = 8;
    localparam int STUFF_LEN = 6;

    typedef logic [BYTE_W-1:0] rx_byte_t;

endpackage

// File: rtl/rx_stuff_counter.sv
// Tracks the run of consecutive accepted 1s and marks the slot that must
// carry a stuffed 0.
module rx_stuff_counter #(
    parameter int STUFF_LEN = rx_pkg::STUFF_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_enable,
    input  logic d_orig,
    input  logic flush,
    output logic is_stuff_slot,
    output logic stuff_violation
);

    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam logic [OW-1:0] SLOT = OW'(STUFF_LEN);

    logic [OW-1:0] ones_cnt_reg;
    logic [OW-1:0] ones_cnt_next;

    assign is_stuff_slot   = (ones_cnt_reg == SLOT);
    assign stuff_violation = is_stuff_slot && d_orig;

    // The run deliberately carries across byte boundaries; only the stuff
    // slot itself, a 0, clear or EOP break it.
    always_comb begin
        ones_cnt_next = ones_cnt_reg;
        if (flush) begin
            ones_cnt_next = '0;
        end else if (shift_enable) begin
            if (is_stuff_slot || !d_orig) begin
                ones_cnt_next = '0;
            end else begin
                ones_cnt_next = ones_cnt_reg + OW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt_reg <= '0;
        end else begin
            ones_cnt_reg <= ones_cnt_next;
        end
    end

endmodule

// File: rtl/rx_unstuff_shifter.sv
// Removes stuffed bits from the decoded USB bit stream and assembles LSB-first
// bytes, flagging stuff violations and EOPs that cut a byte short.
module rx_unstuff_shifter #(
    parameter int BYTE_W    = rx_pkg::BYTE_W,
    parameter int STUFF_LEN = rx_pkg::STUFF_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_orig,
    input  logic              shift_enable,
    input  logic              eop,
    input  logic              clear,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              byte_valid,
    output logic              stuff_err,
    output logic              align_err
);

    localparam int CW = $clog2(BYTE_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(BYTE_W - 1);

    logic [BYTE_W-1:0] shreg_reg;
    logic [CW-1:0]     bit_cnt_reg;
    logic              eop_q_reg;
    logic              is_stuff_slot;
    logic              stuff_violation;
    logic [BYTE_W-1:0] shifted;

    assign shifted = {d_orig, shreg_reg[BYTE_W-1:1]};

    rx_stuff_counter #(
        .STUFF_LEN (STUFF_LEN)
    ) u_stuff_counter (
        .clk             (clk),
        .rst             (rst),
        .shift_enable    (shift_enable),
        .d_orig          (d_orig),
        .flush           (clear || eop),
        .is_stuff_slot   (is_stuff_slot),
        .stuff_violation (stuff_violation)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            eop_q_reg   <= 1'b0;
            rx_byte     <= '0;
            byte_valid  <= 1'b0;
            stuff_err   <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            stuff_err  <= 1'b0;
            align_err  <= 1'b0;
            eop_q_reg  <= eop;
            if (clear) begin
                shreg_reg   <= '0;
                bit_cnt_reg <= '0;
            end else if (eop) begin
                // Only the first EOP cycle may report a partial byte.
                align_err   <= !eop_q_reg && (bit_cnt_reg != '0);
                bit_cnt_reg <= '0;
            end else if (shift_enable) begin
                if (is_stuff_slot) begin
                    stuff_err <= stuff_violation;
                end else begin
                    shreg_reg <= shifted;
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_reg <= '0;
                        rx_byte     <= shifted;
                        byte_valid  <= 1'b1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    end
                end
            end
        end
    end

endmodule
